// File: rtl/fetch_unit.sv
// fetch_unit: rv32i instruction fetch. Holds the PC, fetches one instruction at a
// time over a valid/ready read channel, hands it to decode and computes the next
// PC once the control unit resolves the instruction.
// Optional feature: define FU_MISALIGN_TRAP_EN to halt on a misaligned next PC
// (sticky o_fu_misaligned); otherwise targets are force-aligned and fetch continues.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   // instruction memory read channel
   output logic        o_fu_im_arvalid,
   input  logic        i_fu_im_arready,
   output logic [31:0] o_fu_im_araddr,
   input  logic        i_fu_im_rvalid,
   output logic        o_fu_im_rready,
   input  logic [31:0] i_fu_im_rdata,
   // decode handoff
   output logic        o_fu_id_valid,
   input  logic        i_fu_id_ready,
   output logic [31:0] o_fu_id_inst,
   output logic [31:0] o_fu_id_pc,
   // PC resolution from the control unit
   input  logic        i_fu_pc_valid,
   input  logic [2:0]  i_fu_pc_op_data,
   input  logic [31:0] i_fu_pc_imm,
   input  logic [31:0] i_fu_pc_rs1,
   output logic [31:0] o_fu_pc_ret,
   output logic        o_fu_misaligned
);

   // PC operation encodings shared with the control unit
   localparam logic [2:0]  PcIncr   = 3'd0;
   localparam logic [2:0]  PcBranch = 3'd1;
   localparam logic [2:0]  PcJAL    = 3'd2;
   localparam logic [2:0]  PcJALR   = 3'd3;
   localparam logic [31:0] Nop      = 32'h0000_0013;

`ifdef FU_MISALIGN_TRAP_EN
   typedef enum logic [2:0] {StBoot, StReq, StWait, StIssue, StExec, StHalt} state_e;
`else
   typedef enum logic [2:0] {StBoot, StReq, StWait, StIssue, StExec} state_e;
`endif

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] pc_plus4;
   logic [31:0] jalr_sum;
   logic [31:0] target;
   logic [31:0] next_pc;
`ifdef FU_MISALIGN_TRAP_EN
   logic        misaligned_q, misaligned_d;
   logic        misalign_hit;
`endif

   // Next-PC selection; all arithmetic wraps modulo 2^32
   always_comb begin
      pc_plus4 = pc_q + 32'd4;
      jalr_sum = i_fu_pc_rs1 + i_fu_pc_imm;
      case (i_fu_pc_op_data)
         PcIncr:          target = pc_plus4;
         PcBranch, PcJAL: target = pc_q + i_fu_pc_imm;
         PcJALR:          target = jalr_sum & 32'hFFFF_FFFE;
         default:         target = pc_plus4;
      endcase
`ifdef FU_MISALIGN_TRAP_EN
      next_pc      = target;
      misalign_hit = |target[1:0];
`else
      // Without the trap, silently word-align so fetch never stalls on a bad target
      next_pc = target & 32'hFFFF_FFFC;
`endif
   end

   // FSM next-state, PC update and instruction capture
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
`ifdef FU_MISALIGN_TRAP_EN
      misaligned_d = misaligned_q;
`endif
      case (state_q)
         StBoot: state_d = StReq;
         StReq: begin
            if (i_fu_im_arready) state_d = StWait;
         end
         StWait: begin
            if (i_fu_im_rvalid) begin
               inst_d  = i_fu_im_rdata;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (i_fu_id_ready) state_d = StExec;
         end
         StExec: begin
            if (i_fu_pc_valid) begin
`ifdef FU_MISALIGN_TRAP_EN
               if (misalign_hit) begin
                  // pc keeps the faulting instruction's address for debug
                  misaligned_d = 1'b1;
                  state_d      = StHalt;
               end else begin
                  pc_d    = next_pc;
                  state_d = StReq;
               end
`else
               pc_d    = next_pc;
               state_d = StReq;
`endif
            end
         end
`ifdef FU_MISALIGN_TRAP_EN
         StHalt: state_d = StHalt;
`endif
         default: state_d = StBoot;
      endcase
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StBoot;
         pc_q    <= RESET_PC;
         inst_q  <= Nop;
`ifdef FU_MISALIGN_TRAP_EN
         misaligned_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
`ifdef FU_MISALIGN_TRAP_EN
         misaligned_q <= misaligned_d;
`endif
      end
   end

   // Handshake outputs decode registered state only: no input-to-output paths
   assign o_fu_im_arvalid = (state_q == StReq);
   assign o_fu_im_rready  = (state_q == StWait);
   assign o_fu_id_valid   = (state_q == StIssue);
   assign o_fu_im_araddr  = pc_q;
   assign o_fu_id_inst    = inst_q;
   assign o_fu_id_pc      = pc_q;
   assign o_fu_pc_ret     = pc_plus4;
`ifdef FU_MISALIGN_TRAP_EN
   assign o_fu_misaligned = misaligned_q;
`else
   assign o_fu_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized self-checking bench for fetch_unit with a
// transaction-level reference model of the PC sequence.
module tb_fetch_unit;

   localparam logic [31:0] RstPc    = 32'h0000_0100;
   localparam logic [2:0]  OpIncr   = 3'd0;
   localparam logic [2:0]  OpBranch = 3'd1;
   localparam logic [2:0]  OpJal    = 3'd2;
   localparam logic [2:0]  OpJalr   = 3'd3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        arvalid, arready, rvalid, rready, id_valid, id_ready, pc_valid, misaligned;
   logic [31:0] araddr, rdata, id_inst, id_pc, imm, rs1, pc_ret;
   logic [2:0]  op;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] m_pc;
   bit          m_halted;

   fetch_unit #(.RESET_PC(RstPc)) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .o_fu_im_arvalid (arvalid),
      .i_fu_im_arready (arready),
      .o_fu_im_araddr  (araddr),
      .i_fu_im_rvalid  (rvalid),
      .o_fu_im_rready  (rready),
      .i_fu_im_rdata   (rdata),
      .o_fu_id_valid   (id_valid),
      .i_fu_id_ready   (id_ready),
      .o_fu_id_inst    (id_inst),
      .o_fu_id_pc      (id_pc),
      .i_fu_pc_valid   (pc_valid),
      .i_fu_pc_op_data (op),
      .i_fu_pc_imm     (imm),
      .i_fu_pc_rs1     (rs1),
      .o_fu_pc_ret     (pc_ret),
      .o_fu_misaligned (misaligned)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference next PC straight from the ISA rules
   function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [2:0] o,
                                            input logic [31:0] im, input logic [31:0] r1);
      logic [31:0] t;
      case (o)
         OpBranch, OpJal: t = pc + im;
         OpJalr:          t = (r1 + im) & 32'hFFFF_FFFE;
         default:         t = pc + 32'd4;
      endcase
`ifndef FU_MISALIGN_TRAP_EN
      t = t & 32'hFFFF_FFFC;
`endif
      return t;
   endfunction

   // Randomize every input; phases then override the one handshake they own
   task automatic noise();
      arready  = 1'($urandom_range(1));
      rvalid   = 1'($urandom_range(1));
      id_ready = 1'($urandom_range(1));
      pc_valid = 1'($urandom_range(1));
      rdata    = $urandom;
      op       = 3'($urandom_range(7));
      imm      = $urandom;
      rs1      = $urandom;
   endtask

   task automatic check_reset_vals();
      check_eq("rst_arvalid", 32'(arvalid), 32'd0);
      check_eq("rst_rready", 32'(rready), 32'd0);
      check_eq("rst_id_valid", 32'(id_valid), 32'd0);
      check_eq("rst_inst", id_inst, 32'h0000_0013);
      check_eq("rst_id_pc", id_pc, RstPc);
      check_eq("rst_araddr", araddr, RstPc);
      check_eq("rst_pc_ret", pc_ret, RstPc + 32'd4);
      check_eq("rst_misaligned", 32'(misaligned), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      noise();
      #1 check_reset_vals();
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("boot_no_req", 32'(arvalid), 32'd0);
      m_pc     = RstPc;
      m_halted = 1'b0;
   endtask

   task automatic check_halt();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_eq("halt_arvalid", 32'(arvalid), 32'd0);
         check_eq("halt_rready", 32'(rready), 32'd0);
         check_eq("halt_id_valid", 32'(id_valid), 32'd0);
         check_eq("halt_misaligned", 32'(misaligned), 32'd1);
         check_eq("halt_araddr", araddr, m_pc);
         noise();
      end
   endtask

   // One full instruction; each *_d is the number of stall cycles before the handshake
   task automatic do_instr(input int ar_d, input int rv_d, input int ir_d, input int pv_d,
                           input logic [2:0] op_v, input logic [31:0] imm_v,
                           input logic [31:0] rs1_v, input logic [31:0] word);
      logic [31:0] nxt;
      for (int c = 0; c <= ar_d; c++) begin
         @(negedge clk);
         check_eq("req_arvalid", 32'(arvalid), 32'd1);
         check_eq("req_araddr", araddr, m_pc);
         check_eq("req_rready", 32'(rready), 32'd0);
         check_eq("req_id_valid", 32'(id_valid), 32'd0);
         noise();
         arready = (c == ar_d);
      end
      for (int c = 0; c <= rv_d; c++) begin
         @(negedge clk);
         check_eq("wait_rready", 32'(rready), 32'd1);
         check_eq("wait_arvalid", 32'(arvalid), 32'd0);
         check_eq("wait_id_valid", 32'(id_valid), 32'd0);
         noise();
         rvalid = (c == rv_d);
         if (c == rv_d) rdata = word;
      end
      for (int c = 0; c <= ir_d; c++) begin
         @(negedge clk);
         check_eq("issue_valid", 32'(id_valid), 32'd1);
         check_eq("issue_inst", id_inst, word);
         check_eq("issue_pc", id_pc, m_pc);
         check_eq("issue_arvalid", 32'(arvalid), 32'd0);
         check_eq("issue_rready", 32'(rready), 32'd0);
         noise();
         id_ready = (c == ir_d);
      end
      for (int c = 0; c <= pv_d; c++) begin
         @(negedge clk);
         check_eq("exec_id_valid", 32'(id_valid), 32'd0);
         check_eq("exec_arvalid", 32'(arvalid), 32'd0);
         check_eq("exec_rready", 32'(rready), 32'd0);
         check_eq("exec_pc_ret", pc_ret, m_pc + 32'd4);
         check_eq("exec_misaligned", 32'(misaligned), 32'd0);
         noise();
         pc_valid = (c == pv_d);
         if (c == pv_d) begin
            op  = op_v;
            imm = imm_v;
            rs1 = rs1_v;
         end
      end
      nxt = ref_next(m_pc, op_v, imm_v, rs1_v);
`ifdef FU_MISALIGN_TRAP_EN
      if (nxt[1:0] != 2'b00) m_halted = 1'b1;
      else m_pc = nxt;
`else
      m_pc = nxt;
`endif
      if (m_halted) check_halt();
   endtask

   initial begin
      logic [2:0]  r_op;
      logic [31:0] r_imm, r_rs1;
      noise();
      #12;
      // Reset and first fetch with immediate handshakes
      do_reset();
      do_instr(0, 0, 0, 0, OpIncr, 32'h0, 32'h0, 32'h0000_0093);
      // Sequential fetch under backpressure
      do_reset();
      for (int i = 0; i < 3; i++) do_instr(3, 1, 2, 1, OpIncr, 32'h0, 32'h0, $urandom);
      check_eq("seq_pc_after3", m_pc, 32'h0000_010C);
      // Jump to 0x200, branch back, JALR, wrap, misaligned JAL
      do_instr(0, 0, 0, 0, OpJal, 32'h200 - m_pc, 32'h0, $urandom);
      do_instr(0, 0, 0, 0, OpBranch, 32'hFFFF_FFF0, 32'h0, $urandom);
      do_instr(1, 0, 0, 2, OpJalr, 32'h4, 32'h0000_1001, $urandom);
      do_instr(0, 0, 0, 0, OpJalr, 32'h0, 32'hFFFF_FFFC, $urandom);
      do_instr(0, 0, 0, 0, OpIncr, 32'h0, 32'h0, $urandom);
      check_eq("wrap_pc", m_pc, 32'h0);
      do_instr(0, 0, 0, 0, OpJal, 32'h2, 32'h0, $urandom);
      // Async reset while in WAIT; late rvalid must be dropped
      do_reset();
      @(negedge clk);
      check_eq("mw_arvalid", 32'(arvalid), 32'd1);
      noise();
      arready = 1'b1;
      @(negedge clk);
      check_eq("mw_rready", 32'(rready), 32'd1);
      noise();
      rvalid = 1'b0;
      #2 rst_n = 1'b0;
      #1 check_reset_vals();
      rvalid = 1'b1;
      rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("mw_boot_arvalid", 32'(arvalid), 32'd0);
      check_eq("mw_inst_kept_nop", id_inst, 32'h0000_0013);
      m_pc     = RstPc;
      m_halted = 1'b0;
      do_instr(0, 0, 0, 0, OpIncr, 32'h0, 32'h0, 32'h1234_5678);
      // Randomized instruction stream
      for (int i = 0; i < 60; i++) begin
         r_op  = 3'($urandom_range(7));
         r_imm = $urandom;
         r_rs1 = $urandom;
`ifdef FU_MISALIGN_TRAP_EN
         r_imm = r_imm & 32'hFFFF_FFFC;
         r_rs1 = r_rs1 & 32'hFFFF_FFFC;
`endif
         do_instr($urandom_range(3), $urandom_range(3), $urandom_range(3), $urandom_range(3),
                  r_op, r_imm, r_rs1, $urandom);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
